// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 BRAM arbiter.
package slc3_mem_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam int PORT_CPU     = 0;
   localparam int PORT_LDR     = 1;
   localparam int READ_LAT_DEF = 2;
endpackage

// File: rtl/slc3_mem_arbiter_if.sv
// Requester ports and BRAM-side signals of the arbiter.
interface slc3_mem_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
   logic              cpu_req, cpu_we, cpu_done;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              ldr_req, ldr_we, ldr_done;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
   logic [1:0]        grant;
   logic              busy;
   logic              bram_en, bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din, bram_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata, bram_dout,
      output cpu_rdata, cpu_done, ldr_rdata, ldr_done, grant, busy,
      output bram_en, bram_we, bram_addr, bram_din
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata, bram_dout,
      input  cpu_rdata, cpu_done, ldr_rdata, ldr_done, grant, busy,
      input  bram_en, bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/slc3_mem_arbiter_rr_arb2.sv
// Two-request round-robin picker; on a tie the port that did not own the last transaction wins.
module rr_arb2 (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_owner,
   output logic [1:0] gnt
);
   logic last_owner;

   always_ff @(posedge Clk) begin
      if (!Reset)   last_owner <= 1'b1;
      else if (upd) last_owner <= upd_owner;
   end

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = last_owner ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/slc3_mem_arbiter.sv
// Serialises CPU and loader accesses onto one single-port BRAM, one access in flight.
module slc3_mem_arbiter
   import slc3_mem_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = READ_LAT_DEF
) (
   input  logic Clk,
   input  logic Reset,
   slc3_mem_arbiter_if.slave bus
);
   localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   state_t            state, nxt;
   logic [1:0]        req, pick, grant_q;
   logic              owner, lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata, cpu_rdata_q, ldr_rdata_q;
   logic [CNT_W-1:0]  cnt;

   assign req = {bus.ldr_req, bus.cpu_req};

   rr_arb2 u_arb (
      .Clk       (Clk),
      .Reset     (Reset),
      .req       (req),
      .upd       (state == DONE),
      .upd_owner (owner),
      .gnt       (pick)
   );

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (|req) nxt = ISSUE;
         ISSUE:   nxt = lat_we ? DONE : WAIT;
         WAIT:    if (cnt == '0) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state       <= IDLE;
         grant_q     <= 2'b00;
         owner       <= 1'b0;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         cnt         <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (|req) begin
               grant_q   <= pick;
               owner     <= pick[PORT_LDR];
               lat_we    <= pick[PORT_LDR] ? bus.ldr_we    : bus.cpu_we;
               lat_addr  <= pick[PORT_LDR] ? bus.ldr_addr  : bus.cpu_addr;
               lat_wdata <= pick[PORT_LDR] ? bus.ldr_wdata : bus.cpu_wdata;
            end
            ISSUE: cnt <= CNT_W'(READ_LAT - 1);
            WAIT: begin
               if (cnt == '0) begin
                  if (owner) ldr_rdata_q <= bus.bram_dout;
                  else       cpu_rdata_q <= bus.bram_dout;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    grant_q <= 2'b00;
            default: ;
         endcase
      end
   end

   // Address/data come straight from the latches, so they only move on entry to ISSUE.
   assign bus.bram_en   = (state == ISSUE) || (state == WAIT);
   assign bus.bram_we   = (state == ISSUE) && lat_we;
   assign bus.bram_addr = lat_addr;
   assign bus.bram_din  = lat_wdata;
   assign bus.cpu_done  = (state == DONE) && grant_q[PORT_CPU];
   assign bus.ldr_done  = (state == DONE) && grant_q[PORT_LDR];
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.ldr_rdata = ldr_rdata_q;
   assign bus.grant     = grant_q;
   assign bus.busy      = (state != IDLE);
endmodule
